// File: rtl/oc_clock_monitor.sv
// Per-channel clock monitor: counts divided-clock toggle edges over a fixed window and streams
// one report beat per channel. Optional liveness flags are built when OC_CLOCK_MONITOR_ALIVE_EN is defined.
module oc_clock_monitor #(
    parameter int Channels     = 4,
    parameter int WindowCycles = 1000,
    parameter int CountWidth   = 16,
    parameter int ClockIdBase  = 200,
    parameter int MinCount     = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [Channels-1:0]   toggle_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_id,
    output logic [CountWidth-1:0] out_count,
    output logic                  out_last,
    output logic                  overrun,
    input  logic                  overrun_clear,
    output logic [Channels-1:0]   alive,
    output logic                  dead_any
);

    localparam int WinW  = (WindowCycles > 1) ? $clog2(WindowCycles) : 1;
    localparam int ChanW = (Channels > 1) ? $clog2(Channels) : 1;
    localparam logic [WinW-1:0]  WinLast  = WinW'(WindowCycles - 1);
    localparam logic [ChanW-1:0] ChanLast = ChanW'(Channels - 1);

    typedef enum logic {IDLE, REPORT} state_e;

    state_e                               stateQ, stateD;
    logic [Channels-1:0]                  toggleQ;
    logic                                 primedQ;
    logic [WinW-1:0]                      winCntQ, winCntD;
    logic [ChanW-1:0]                     chanQ, chanD;
    logic                                 overrunQ, overrunD;
    logic [Channels-1:0][CountWidth-1:0]  countQ, countD;
    logic [Channels-1:0][CountWidth-1:0]  snapQ, snapD;
    logic [Channels-1:0][CountWidth-1:0]  sumCount;
    logic [Channels-1:0]                  edges;
    logic                                 windowEnd;
    logic                                 accept;
    logic                                 lastBeat;
    logic                                 lastAccept;
    logic                                 capture;

    // The first cycle after reset has no valid previous sample, so its edges are discarded.
    always_comb begin
        edges      = primedQ ? (toggle_in ^ toggleQ) : '0;
        windowEnd  = (winCntQ == WinLast);
        accept     = (stateQ == REPORT) && out_ready;
        lastBeat   = (chanQ == ChanLast);
        lastAccept = accept && lastBeat;
        capture    = windowEnd && ((stateQ == IDLE) || lastAccept);
        for (int i = 0; i < Channels; i++) begin
            sumCount[i] = (countQ[i] == '1) ? countQ[i] : countQ[i] + CountWidth'(edges[i]);
        end
    end

    // Report sequencing; a window that ends mid-report is dropped and flagged instead of captured.
    always_comb begin
        stateD   = stateQ;
        chanD    = chanQ;
        overrunD = overrunQ;
        snapD    = snapQ;
        winCntD  = windowEnd ? '0 : winCntQ + WinW'(1);
        countD   = windowEnd ? '0 : sumCount;
        if (overrun_clear) begin
            overrunD = 1'b0;
        end
        if (windowEnd && (stateQ == REPORT) && !lastAccept) begin
            overrunD = 1'b1;
        end
        if (capture) begin
            stateD = REPORT;
            chanD  = '0;
            snapD  = sumCount;
        end else if (accept) begin
            if (lastBeat) begin
                stateD = IDLE;
                chanD  = '0;
            end else begin
                chanD = chanQ + ChanW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ   <= IDLE;
            toggleQ  <= '0;
            primedQ  <= 1'b0;
            winCntQ  <= '0;
            chanQ    <= '0;
            overrunQ <= 1'b0;
            countQ   <= '0;
            snapQ    <= '0;
        end else begin
            stateQ   <= stateD;
            toggleQ  <= toggle_in;
            primedQ  <= 1'b1;
            winCntQ  <= winCntD;
            chanQ    <= chanD;
            overrunQ <= overrunD;
            countQ   <= countD;
            snapQ    <= snapD;
        end
    end

    assign out_valid = (stateQ == REPORT);
    assign out_last  = (stateQ == REPORT) && lastBeat;
    assign out_id    = 16'(ClockIdBase) + 16'(chanQ);
    assign out_count = snapQ[chanQ];
    assign overrun   = overrunQ;

`ifdef OC_CLOCK_MONITOR_ALIVE_EN
    localparam logic [CountWidth-1:0] MinCountW = CountWidth'(MinCount);

    logic [Channels-1:0] aliveQ, aliveD;
    logic                deadQ;
    logic                winEndQ;

    // Liveness is judged on the full window count, independent of whether the report was captured.
    always_comb begin
        aliveD = aliveQ;
        if (windowEnd) begin
            for (int i = 0; i < Channels; i++) begin
                aliveD[i] = (sumCount[i] >= MinCountW);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            aliveQ  <= '0;
            deadQ   <= 1'b0;
            winEndQ <= 1'b0;
        end else begin
            aliveQ  <= aliveD;
            winEndQ <= windowEnd;
            if (winEndQ) begin
                deadQ <= |(~aliveQ);
            end
        end
    end

    assign alive    = aliveQ;
    assign dead_any = deadQ;
`else
    assign alive    = '0;
    assign dead_any = 1'b0;
`endif

endmodule

// File: tb/tb_oc_clock_monitor.sv
// Randomised self-checking bench for oc_clock_monitor against a queue-based window/report model.
module tb_oc_clock_monitor;

    localparam int CH   = 4;
    localparam int WIN  = 100;
    localparam int CW   = 8;
    localparam int BASE = 200;
    localparam int MINC = 10;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] toggle_in = '0;
    logic          out_ready = 1'b0;
    logic          overrun_clear = 1'b0;
    logic          out_valid, out_last, overrun, dead_any;
    logic [15:0]   out_id;
    logic [CW-1:0] out_count;
    logic [CH-1:0] alive;

    logic          readyTied = 1'b1;
    logic          clearTied = 1'b0;
    logic          outValid2, outLast2, overrun2, deadAny2;
    logic [15:0]   outId2;
    logic [5:0]    outCount2;
    logic [CH-1:0] alive2;

    oc_clock_monitor #(.Channels(CH), .WindowCycles(WIN), .CountWidth(CW),
                       .ClockIdBase(BASE), .MinCount(MINC)) dut (
        .clock(clock), .reset_n(reset_n), .toggle_in(toggle_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_count(out_count), .out_last(out_last), .overrun(overrun),
        .overrun_clear(overrun_clear), .alive(alive), .dead_any(dead_any));

    oc_clock_monitor #(.Channels(CH), .WindowCycles(WIN), .CountWidth(6),
                       .ClockIdBase(BASE), .MinCount(MINC)) dutSat (
        .clock(clock), .reset_n(reset_n), .toggle_in(toggle_in),
        .out_valid(outValid2), .out_ready(readyTied), .out_id(outId2),
        .out_count(outCount2), .out_last(outLast2), .overrun(overrun2),
        .overrun_clear(clearTied), .alive(alive2), .dead_any(deadAny2));

    always #5 clock = ~clock;

    typedef struct {
        int id;
        int count;
        bit last;
    } beat_t;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: live counts per window and the queue of beats still to be reported.
    int      mCount [CH];
    int      mWin;
    bit      mPrimed;
    bit [CH-1:0] mPrev;
    bit      mOverrun;
    bit [CH-1:0] mAlive;
    bit      mDead;
    bit      mDeadPend;
    bit      alignHit;
    beat_t   mQ[$];
    beat_t   dutLog[$];
    int      dutLogStep[$];
    int      sinceRel;

    int  tick = 0;
    int  toggleMode = 0;
    int  readyMode = 0;
    bit  clearReq = 0;
    bit  randClear = 0;
    bit  sat2Mode = 0;
    bit  rstReq = 0;
    int  rstCycles = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < CH; i++) mCount[i] = 0;
        mWin = 0;
        mPrimed = 0;
        mPrev = '0;
        mOverrun = 0;
        mAlive = '0;
        mDead = 0;
        mDeadPend = 0;
        mQ.delete();
        dutLog.delete();
        dutLogStep.delete();
        sinceRel = 0;
    endtask

    task automatic resetChecks();
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_last", out_last, 0);
        checkOutput("rst_id", out_id, BASE);
        checkOutput("rst_count", out_count, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_alive", alive, 0);
        checkOutput("rst_dead", dead_any, 0);
        checkOutput("rst_valid_sat", outValid2, 0);
    endtask

    task automatic compareOutputs();
        bit expValid;
        expValid = (mQ.size() > 0);
        sinceRel++;
        checkOutput("out_valid", out_valid, expValid);
        if (expValid) begin
            checkOutput("out_id", out_id, mQ[0].id);
            checkOutput("out_count", out_count, mQ[0].count);
            checkOutput("out_last", out_last, mQ[0].last);
        end else begin
            checkOutput("out_last_idle", out_last, 0);
        end
        checkOutput("overrun", overrun, mOverrun);
`ifdef OC_CLOCK_MONITOR_ALIVE_EN
        checkOutput("alive", alive, mAlive);
        checkOutput("dead_any", dead_any, mDead);
`else
        checkOutput("alive_off", alive, 0);
        checkOutput("dead_off", dead_any, 0);
`endif
        if (sat2Mode && outValid2 && outId2 == 16'(BASE)) begin
            checkOutput("sat_count", outCount2, 63);
        end
        if (out_valid && out_ready) begin
            dutLog.push_back('{id: int'(out_id), count: int'(out_count), last: out_last});
            dutLogStep.push_back(sinceRel);
        end
    endtask

    task automatic applyStimulus();
        tick++;
        if (toggleMode == 0) begin
            toggle_in[0] = ~toggle_in[0];
            if (tick % 2 == 0) toggle_in[1] = ~toggle_in[1];
            if (tick % 4 == 0) toggle_in[2] = ~toggle_in[2];
        end else begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 9) < (i + 1) * 2) toggle_in[i] = ~toggle_in[i];
            end
        end
        case (readyMode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = (mQ.size() > 0) && (mWin >= WIN - mQ.size());
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
        overrun_clear = clearReq || (randClear && $urandom_range(0, 40) == 0);
        clearReq = 0;
    endtask

    // Advances the model across the coming rising edge using the inputs just driven.
    task automatic modelUpdate();
        bit accepted;
        bit lastAcc;
        int sat;
        accepted = 0;
        lastAcc = 0;
        for (int i = 0; i < CH; i++) begin
            if (mPrimed && toggle_in[i] != mPrev[i]) mCount[i]++;
        end
        mPrev = toggle_in;
        mPrimed = 1;
        if (mQ.size() > 0 && out_ready) begin
            accepted = 1;
            lastAcc = mQ[0].last;
            void'(mQ.pop_front());
        end
        if (overrun_clear) mOverrun = 0;
        if (mDeadPend) begin
            mDead = |(~mAlive);
            mDeadPend = 0;
        end
        if (mWin == WIN - 1) begin
            if (mQ.size() == 0) begin
                for (int i = 0; i < CH; i++) begin
                    sat = (mCount[i] > (1 << CW) - 1) ? (1 << CW) - 1 : mCount[i];
                    mQ.push_back('{id: BASE + i, count: sat, last: (i == CH - 1)});
                end
                if (accepted && lastAcc) alignHit = 1;
            end else begin
                mOverrun = 1;
            end
            for (int i = 0; i < CH; i++) begin
                mAlive[i] = (mCount[i] >= MINC);
                mCount[i] = 0;
            end
            mDeadPend = 1;
            mWin = 0;
        end else begin
            mWin++;
        end
    endtask

    task automatic step();
        @(negedge clock);
        if (rstCycles > 0) begin
            rstCycles--;
            if (rstCycles == 0) begin
                reset_n = 1'b1;
                applyStimulus();
                modelUpdate();
            end
        end else begin
            compareOutputs();
            if (rstReq) begin
                rstReq = 0;
                reset_n = 1'b0;
                #1;
                resetChecks();
                modelReset();
                rstCycles = 3;
            end else begin
                applyStimulus();
                modelUpdate();
            end
        end
    endtask

    initial begin
        int guard;
        modelReset();
        #1;
        resetChecks();
        rstCycles = 3;

        // Fixed-rate toggles with an always-ready sink.
        toggleMode = 0;
        readyMode = 0;
        sat2Mode = 1;
        repeat (263) step();
        checkOutput("log_size", (dutLog.size() >= 8), 1);
        if (dutLog.size() >= 8) begin
            for (int i = 0; i < CH; i++) begin
                checkOutput("win2_id", dutLog[4 + i].id, BASE + i);
                checkOutput("win2_last", dutLog[4 + i].last, (i == CH - 1));
            end
            checkOutput("win2_c0", dutLog[4].count, 100);
            checkOutput("win2_c1", dutLog[5].count, 50);
            checkOutput("win2_c2", dutLog[6].count, 25);
            checkOutput("win2_c3", dutLog[7].count, 0);
        end
`ifdef OC_CLOCK_MONITOR_ALIVE_EN
        checkOutput("alive_pat", alive, 4'b0111);
        checkOutput("dead_pat", dead_any, 1);
`else
        checkOutput("alive_pat_off", alive, 0);
        checkOutput("dead_pat_off", dead_any, 0);
`endif

        // Stalled sink across a window end.
        readyMode = 1;
        guard = 0;
        while (mQ.size() == 0 && guard < 300) begin
            step();
            guard++;
        end
        checkOutput("stall_wait_timeout", (guard < 300), 1);
        repeat (150) step();
        checkOutput("stall_overrun", overrun, 1);
        checkOutput("stall_held_id", out_id, BASE);
        checkOutput("stall_held_count", out_count, 100);
        clearReq = 1;
        step();
        step();
        checkOutput("overrun_cleared", overrun, 0);

        // Last beat accepted exactly in the window-end cycle.
        readyMode = 2;
        alignHit = 0;
        guard = 0;
        while (!alignHit && guard < 400) begin
            step();
            guard++;
        end
        checkOutput("align_timeout", alignHit, 1);
        step();
        checkOutput("align_overrun", overrun, 0);
        checkOutput("align_valid", out_valid, 1);
        checkOutput("align_id", out_id, BASE);

        // Random toggles, backpressure and clears.
        sat2Mode = 0;
        toggleMode = 1;
        readyMode = 3;
        randClear = 1;
        repeat (700) step();
        randClear = 0;

        // Reset in the middle of the ch2 beat, then check priming on the first window.
        toggleMode = 0;
        readyMode = 0;
        guard = 0;
        while (!(mQ.size() > 0 && mQ[0].id == BASE + 2) && guard < 400) begin
            step();
            guard++;
        end
        checkOutput("ch2_wait_timeout", (guard < 400), 1);
        rstReq = 1;
        step();
        sat2Mode = 1;
        repeat (110) step();
        checkOutput("prime_log", (dutLog.size() > 0), 1);
        if (dutLog.size() > 0) begin
            checkOutput("prime_id", dutLog[0].id, BASE);
            checkOutput("prime_count", dutLog[0].count, 99);
            checkOutput("prime_latency", dutLogStep[0], 100);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
